// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: FSM states, MODE codes,
// register offsets inside a channel's 16-byte window and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_TERM = 2'd3
    } state_e;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;
    localparam logic [1:0] MODE_TOGGLE  = 2'b10;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PSC_LSB  = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, IDLE-LOAD-CNT-TERM FSM, PEND, tout.
// Latency: PEND rises P+2 edges after EN is written (P=0 acts as 1); read data is combinational.
// Backpressure: none; a bus write to this channel freezes the FSM, COUNT and PEND for that cycle.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_vld,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wr_dat,
    output logic [31:0] rd_dat,
    output logic        irq,
    output logic        tout
);

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pend_q, pend_d;
    logic               tout_q, tout_d;
    logic               step;
    logic               unused_wr;

`ifdef PRESCALE_EN
    logic [7:0]         psc_q, psc_d;
    logic [7:0]         psc_cnt_q, psc_cnt_d;
    assign step = (psc_cnt_q == psc_q);
`else
    assign step = 1'b1;
`endif

    // Only a subset of the write bits land in registers.
    assign unused_wr = ^wr_dat;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        tout_d   = tout_q;
`ifdef PRESCALE_EN
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
`endif
        if (wr_vld) begin
`ifdef PRESCALE_EN
            psc_cnt_d = 8'd0;
`endif
            case (reg_sel)
                REG_CTRL: begin
                    en_d   = wr_dat[CTRL_EN];
                    mode_d = wr_dat[CTRL_MODE_LSB +: 2];
                    im_d   = wr_dat[CTRL_IM];
`ifdef PRESCALE_EN
                    psc_d  = wr_dat[CTRL_PSC_LSB +: 8];
`endif
                end
                REG_PRESET: preset_d = wr_dat[CNT_W-1:0];
                REG_COUNT:  count_d  = wr_dat[CNT_W-1:0];
                default:    if (wr_dat[0]) pend_d = 1'b0;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef PRESCALE_EN
                    psc_cnt_d = 8'd0;
`endif
                    if (en_q) state_d = ST_LOAD;
                end
                ST_LOAD: begin
`ifdef PRESCALE_EN
                    psc_cnt_d = 8'd0;
`endif
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
                ST_CNT: begin
                    if (!en_q) begin
                        state_d = ST_IDLE;
                    end else if (step) begin
`ifdef PRESCALE_EN
                        psc_cnt_d = 8'd0;
`endif
                        if (count_q > CNT_W'(1)) begin
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            count_d = '0;
                            pend_d  = 1'b1;
                            state_d = ST_TERM;
                        end
                    end else begin
`ifdef PRESCALE_EN
                        psc_cnt_d = psc_cnt_q + 8'd1;
`endif
                    end
                end
                default: begin
                    if (mode_q == MODE_ONESHOT) begin
                        en_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Mode 11 reloads like 01; only 10 flips the output.
                        count_d = preset_q;
                        state_d = ST_CNT;
                        if (mode_q == MODE_TOGGLE) tout_d = ~tout_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            tout_q   <= 1'b0;
`ifdef PRESCALE_EN
            psc_q     <= 8'd0;
            psc_cnt_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            tout_q   <= tout_d;
`ifdef PRESCALE_EN
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
`endif
        end
    end

    always_comb begin
        rd_dat = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_dat[CTRL_EN]            = en_q;
                rd_dat[CTRL_MODE_LSB +: 2] = mode_q;
                rd_dat[CTRL_IM]            = im_q;
`ifdef PRESCALE_EN
                rd_dat[CTRL_PSC_LSB +: 8]  = psc_q;
`endif
            end
            REG_PRESET: rd_dat = 32'(preset_q);
            REG_COUNT:  rd_dat = 32'(count_q);
            default:    rd_dat[0] = pend_q;
        endcase
    end

    assign irq  = pend_q & im_q;
    assign tout = tout_q;

endmodule

// File: rtl/multi_timer.sv
// NUM_CH-channel memory-mapped timer: address decode, read mux, IRQ OR. Optional PRESCALE_EN adds CTRL[15:8] prescaler.
// Latency: Dout is combinational from Addr; IRQ follows PEND&IM with no extra delay.
// Backpressure: none; a write stalls only the addressed channel for that cycle.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic              IRQ,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] tout
);

    localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [1:0]       reg_sel;
    logic [CH_AW-1:0] ch_idx;
    logic             ch_hit;
    logic [31:0]      ch_rd [NUM_CH];

    assign reg_sel = Addr[1:0];
    assign ch_idx  = Addr[CH_AW+1:2];
    // Any address bit above the channel field selects no channel, so aliases read 0.
    assign ch_hit  = (Addr[29:CH_AW+2] == '0) && (int'(ch_idx) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr_vld;
        assign ch_wr_vld = WE && ch_hit && (ch_idx == CH_AW'(g));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst_n   (reset),
            .wr_vld  (ch_wr_vld),
            .reg_sel (reg_sel),
            .wr_dat  (Din),
            .rd_dat  (ch_rd[g]),
            .irq     (irq_vec[g]),
            .tout    (tout[g])
        );
    end

    always_comb begin
        Dout = '0;
        if (ch_hit) Dout = ch_rd[ch_idx];
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: register table plus timed sequences for
// latency, auto-reload, toggle, write stall, disable and asynchronous reset.
module tb_multi_timer;

    localparam int R_CTRL = 0, R_PRESET = 1, R_COUNT = 2, R_STATUS = 3;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic [1:0]  irq_vec;
    logic [1:0]  tout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        bit          we;
        int          ch;
        int          r;
        logic [31:0] dat;
        string       name;
    } vec_t;
    vec_t tbl[13];

    multi_timer #(.NUM_CH(2), .CNT_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .irq_vec (irq_vec),
        .tout    (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] a(input int ch, input int r);
        return 30'(ch * 4 + r);
    endfunction

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return IRQ;
            1:       return irq_vec[0];
            2:       return irq_vec[1];
            3:       return tout[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        Addr = a(ch, r);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    // Expected value is queued with the address, then popped against Dout.
    task automatic rd(input int ch, input int r, input logic [31:0] exp, input string name);
        sb_t s;
        sb_q.push_back('{name, exp});
        Addr = a(ch, r);
        #1;
        s = sb_q.pop_front();
        check(s.name, Dout, s.exp);
    endtask

    task automatic wait_level(input int sel, input logic lvl, input int budget, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (get_sig(sel) == lvl) seen = 1'b1;
        end
        if (!seen) edges = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [31:0] ctrl_rb;
`ifdef PRESCALE_EN
        ctrl_rb = 32'hFF06;
`else
        ctrl_rb = 32'h0006;
`endif
        tbl[0]  = '{1'b0, 0, R_CTRL,   32'h0,        "rst ctrl0"};
        tbl[1]  = '{1'b0, 1, R_COUNT,  32'h0,        "rst count1"};
        tbl[2]  = '{1'b0, 1, R_STATUS, 32'h0,        "rst status1"};
        tbl[3]  = '{1'b1, 0, R_PRESET, 32'hDEADBEEF, "wr preset0"};
        tbl[4]  = '{1'b0, 0, R_PRESET, 32'hDEADBEEF, "rd preset0"};
        tbl[5]  = '{1'b1, 0, R_CTRL,   32'h0000FFF6, "wr ctrl0"};
        tbl[6]  = '{1'b0, 0, R_CTRL,   ctrl_rb,      "rd ctrl0 masked"};
        tbl[7]  = '{1'b1, 1, R_COUNT,  32'h55,       "wr count1"};
        tbl[8]  = '{1'b0, 1, R_COUNT,  32'h55,       "rd count1"};
        tbl[9]  = '{1'b1, 7, R_PRESET, 32'h77,       "wr ch7"};
        tbl[10] = '{1'b0, 1, R_PRESET, 32'h0,        "ch7 write no alias"};
        tbl[11] = '{1'b0, 7, R_PRESET, 32'h0,        "rd ch7"};
        tbl[12] = '{1'b0, 0, R_COUNT,  32'h0,        "rd count0 idle"};

        reset = 1'b0;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        #3;
        check("rst IRQ", 32'(IRQ), 32'h0);
        check("rst irq_vec", 32'(irq_vec), 32'h0);
        check("rst tout", 32'(tout), 32'h0);
        check("rst Dout", Dout, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].we) bus_wr(tbl[i].ch, tbl[i].r, tbl[i].dat);
            else           rd(tbl[i].ch, tbl[i].r, tbl[i].dat, tbl[i].name);
        end

        // One-shot with IRQ, W1C behaviour.
        do_reset();
        bus_wr(0, R_PRESET, 5);
        bus_wr(0, R_CTRL, 32'h9);
        wait_level(0, 1'b1, 40, e);
        check("oneshot irq edge", 32'(e), 32'd7);
        check("oneshot irq_vec", 32'(irq_vec), 32'h1);
        rd(0, R_COUNT, 32'h0, "oneshot count");
        @(posedge clk);
        #1;
        rd(0, R_CTRL, 32'h8, "oneshot ctrl EN cleared");
        repeat (3) @(posedge clk);
        #1;
        check("irq held", 32'(IRQ), 32'h1);
        bus_wr(0, R_STATUS, 32'h0);
        check("w1c zero no effect", 32'(IRQ), 32'h1);
        bus_wr(0, R_STATUS, 32'h1);
        check("w1c clears irq", 32'(IRQ), 32'h0);
        rd(0, R_STATUS, 32'h0, "w1c status");

        // Auto-reload on ch1, W1C after each pulse, then W1C on the terminal cycle.
        do_reset();
        bus_wr(1, R_PRESET, 3);
        bus_wr(1, R_CTRL, 32'hB);
        wait_level(2, 1'b1, 40, e);
        check("reload first edge", 32'(e), 32'd5);
        for (int p = 0; p < 3; p++) begin
            bus_wr(1, R_STATUS, 32'h1);
            check("reload w1c", 32'(irq_vec[1]), 32'h0);
            wait_level(2, 1'b1, 20, e);
            check("reload period", 32'(e), 32'd4);
            check("ch0 untouched", 32'(irq_vec[0]), 32'h0);
        end
        bus_wr(1, R_STATUS, 32'h1);
        repeat (3) @(posedge clk);
        bus_wr(1, R_STATUS, 32'h1);
        check("stall on terminal", 32'(irq_vec[1]), 32'h0);
        @(posedge clk);
        #1;
        check("terminal after stall", 32'(irq_vec[1]), 32'h1);
        rd(1, R_STATUS, 32'h1, "pend ends set");

        // Toggle mode: tout flips every P+1 cycles, COUNT reloads.
        do_reset();
        bus_wr(0, R_PRESET, 2);
        bus_wr(0, R_CTRL, 32'h5);
        wait_level(3, 1'b1, 40, e);
        check("toggle first rise", 32'(e), 32'd5);
        rd(0, R_COUNT, 32'h2, "toggle reload count");
        wait_level(3, 1'b0, 20, e);
        check("toggle fall", 32'(e), 32'd3);
        rd(0, R_COUNT, 32'h2, "toggle reload count 2");
        wait_level(3, 1'b1, 20, e);
        check("toggle rise", 32'(e), 32'd3);
        check("IM off no irq", 32'(IRQ), 32'h0);
        rd(0, R_STATUS, 32'h1, "pend without IM");
        bus_wr(0, R_CTRL, 32'hD);
        check("IM on raises irq", 32'(IRQ), 32'h1);

        // Mid-count disable freezes COUNT.
        do_reset();
        bus_wr(0, R_PRESET, 20);
        bus_wr(0, R_CTRL, 32'h1);
        repeat (6) @(posedge clk);
        bus_wr(0, R_CTRL, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rd(0, R_COUNT, 32'd16, "disable freezes count");
        rd(0, R_STATUS, 32'h0, "disable no pend");

        // Asynchronous reset between edges.
        do_reset();
        bus_wr(1, R_PRESET, 3);
        bus_wr(1, R_CTRL, 32'hB);
        bus_wr(0, R_PRESET, 2);
        bus_wr(0, R_CTRL, 32'h5);
        wait_level(3, 1'b1, 40, e);
        check("pre-reset irq", 32'(IRQ), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async rst IRQ", 32'(IRQ), 32'h0);
        check("async rst irq_vec", 32'(irq_vec), 32'h0);
        check("async rst tout", 32'(tout), 32'h0);
        rd(1, R_PRESET, 32'h0, "async rst preset1");
        rd(1, R_CTRL, 32'h0, "async rst ctrl1");
        @(negedge clk);
        reset = 1'b1;

`ifdef PRESCALE_EN
        do_reset();
        bus_wr(0, R_PRESET, 4);
        bus_wr(0, R_CTRL, 32'h0109);
        wait_level(0, 1'b1, 40, e);
        check("prescale irq edge", 32'(e), 32'd10);
        @(posedge clk);
        #1;
        rd(0, R_CTRL, 32'h0108, "prescale ctrl rb");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
